// File: rtl/vc_output_arbiter_pkg.sv
// rtl/vc_output_arbiter_pkg.sv - shared VC encodings, default widths and packet VC extraction
package vc_output_arbiter_pkg;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_VC_BIT     = 63;
  // Widest packet the VC helper accepts; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH     = 1024;

  function automatic logic pkt_vc(input logic [MAX_DATA_WIDTH-1:0] pkt, input int vc_bit);
    return pkt[vc_bit];
  endfunction

endpackage

// File: rtl/vc_output_arbiter_rr_arbiter.sv
// rtl/vc_output_arbiter_rr_arbiter.sv - round-robin pick of the first eligible index at or after ptr
module vc_output_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[(int'(ptr) + k) % NUM_REQ]) begin
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// rtl/vc_output_arbiter.sv - shares one output link between requesters using two alternating VC buffers
module vc_output_arbiter
  import vc_output_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 3,
  parameter int VC_BIT     = DEFAULT_VC_BIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          polarity,
  output logic                          net_so,
  input  logic                          net_ro,
  output logic [DATA_WIDTH-1:0]         net_do
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [1:0]            buf_full;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [PTR_W-1:0]      rr_ptr [2];

  logic                  vc_int;
  logic                  vc_ext;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    arb_grant;
  logic                  arb_found;
  logic                  fill;
  logic [PTR_W-1:0]      win;
  logic [DATA_WIDTH-1:0] win_data;

  // The VC being filled this cycle is the polarity; the other one drains.
  assign vc_int = polarity ? VC_ODD : VC_EVEN;
  assign vc_ext = ~vc_int;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && !buf_full[vc_int] &&
                    (pkt_vc(MAX_DATA_WIDTH'(req_data[i*DATA_WIDTH +: DATA_WIDTH]), VC_BIT) == vc_int);
    end
  end

  vc_output_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (rr_ptr[vc_int]),
    .grant    (arb_grant),
    .found    (arb_found)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) win = PTR_W'(i);
    end
  end

  assign win_data = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];

  // Requesters pop on gnt, so it must be silent while reset is held.
  assign fill   = arb_found && reset;
  assign gnt    = reset ? arb_grant : '0;
  assign net_so = buf_full[vc_ext];
  assign net_do = net_so ? buf_data[vc_ext] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity    <= 1'b0;
      buf_full    <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      rr_ptr[0]   <= '0;
      rr_ptr[1]   <= '0;
    end else begin
      polarity <= ~polarity;
      if (fill) begin
        buf_full[vc_int] <= 1'b1;
        buf_data[vc_int] <= win_data;
        rr_ptr[vc_int]   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (net_so && net_ro) begin
        buf_full[vc_ext] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// tb/tb_vc_output_arbiter.sv - vector table, directed corner sequences and random model check
module tb_vc_output_arbiter;

  localparam int DW = 64;
  localparam int NR = 3;
  localparam logic [63:0] ODD = 64'h8000_0000_0000_0000;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             polarity;
  logic             net_so;
  logic             net_ro;
  logic [DW-1:0]    net_do;

  int total_cnt;
  int pass_cnt;

  vc_output_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .polarity (polarity),
    .net_so   (net_so),
    .net_ro   (net_ro),
    .net_do   (net_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [63:0] d0, d1, d2;
    logic        ro;
    logic [2:0]  gnt;
    logic        so;
    logic [63:0] dout;
    logic        pol;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input logic [2:0] r, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic ro);
    req      = r;
    req_data = {c, b, a};
    net_ro   = ro;
  endtask

  task automatic check_out(input string tag, input logic [2:0] eg, input logic es,
                           input logic [63:0] ed, input logic ep);
    chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
    chk({tag, ".net_so"}, 64'(net_so), 64'(es));
    chk({tag, ".net_do"}, net_do, ed);
    chk({tag, ".polarity"}, 64'(polarity), 64'(ep));
  endtask

  task automatic do_reset();
    set_in(3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Behavioural reference: two single-slot buffers, two pointers, alternating polarity.
  logic        m_valid [2];
  logic [63:0] m_data  [2];
  int          m_ptr   [2];
  logic        m_pol;
  logic        pend    [NR];
  logic [63:0] pdata   [NR];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_ptr[i]   = 0;
    end
    m_pol = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
  endtask

  initial begin
    logic [2:0]  r;
    logic [2:0]  eg;
    logic [63:0] ed;
    int          v, u, w;
    logic        ro;

    total_cnt = 0;
    pass_cnt  = 0;
    reset     = 1'b0;
    set_in(3'b111, 64'd1, 64'd2, 64'd3, 1'b1);
    #2;
    check_out("in_reset", 3'b000, 1'b0, 64'd0, 1'b0);

    vecs[0]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b0};
    vecs[1]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b1};
    vecs[2]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b0};
    vecs[3]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b1};
    vecs[4]  = '{3'b010, 64'd0, 64'hAA, 64'd0, 1'b1, 3'b010, 1'b0, 64'd0, 1'b0};
    vecs[5]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b1, 64'hAA, 1'b1};
    vecs[6]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b0};
    vecs[7]  = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b1};
    vecs[8]  = '{3'b001, ODD | 64'hBB, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b0};
    vecs[9]  = '{3'b001, ODD | 64'hBB, 64'd0, 64'd0, 1'b1, 3'b001, 1'b0, 64'd0, 1'b1};
    vecs[10] = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b1, ODD | 64'hBB, 1'b0};
    vecs[11] = '{3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 3'b000, 1'b0, 64'd0, 1'b1};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].r, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].ro);
      #2;
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].so, vecs[i].dout, vecs[i].pol);
      @(negedge clk);
    end

    // Fairness: three even requesters held continuously.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(3'b111, 64'h10, 64'h11, 64'h12, 1'b1);
      #2;
      if (k % 2 == 0) check_out($sformatf("fair%0d", k), 3'(1 << ((k / 2) % 3)), 1'b0, 64'd0, 1'b0);
      else check_out($sformatf("fair%0d", k), 3'b000, 1'b1, 64'h10 + 64'((k / 2) % 3), 1'b1);
      @(negedge clk);
    end

    // Backpressure on the even VC for six cycles.
    do_reset();
    set_in(3'b100, 64'd0, 64'd0, 64'hCC, 1'b0);
    #2;
    check_out("bp_fill", 3'b100, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      set_in(3'b100, 64'd0, 64'd0, 64'hDD, 1'b0);
      #2;
      if (k % 2 == 1) check_out($sformatf("bp_hold%0d", k), 3'b000, 1'b1, 64'hCC, 1'b1);
      else check_out($sformatf("bp_hold%0d", k), 3'b000, 1'b0, 64'd0, 1'b0);
      @(negedge clk);
    end
    set_in(3'b100, 64'd0, 64'd0, 64'hDD, 1'b1);
    #2;
    check_out("bp_drain", 3'b000, 1'b1, 64'hCC, 1'b1);
    @(negedge clk);
    #2;
    check_out("bp_regrant", 3'b100, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    set_in(3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
    #2;
    check_out("bp_out", 3'b000, 1'b1, 64'hDD, 1'b1);
    @(negedge clk);

    // Reset while both buffers hold packets.
    do_reset();
    set_in(3'b001, 64'hE1, 64'd0, 64'd0, 1'b0);
    #2;
    check_out("mr_a", 3'b001, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    set_in(3'b010, 64'd0, ODD | 64'h01, 64'd0, 1'b0);
    #2;
    check_out("mr_b", 3'b010, 1'b1, 64'hE1, 1'b1);
    @(negedge clk);
    set_in(3'b111, 64'hE2, ODD | 64'h02, 64'hE3, 1'b0);
    #2;
    check_out("mr_c", 3'b000, 1'b1, ODD | 64'h01, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check_out("mr_in_reset", 3'b000, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    set_in(3'b111, 64'hE2, 64'hE4, 64'hE3, 1'b1);
    #2;
    check_out("mr_first", 3'b001, 1'b0, 64'd0, 1'b0);
    @(negedge clk);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pdata[i] = {32'($urandom), 32'($urandom)};
        end
        r[i] = pend[i];
      end
      ro = ($urandom_range(0, 3) != 0);
      set_in(r, pdata[0], pdata[1], pdata[2], ro);
      v  = int'(m_pol);
      u  = 1 - v;
      eg = '0;
      w  = -1;
      if (!m_valid[v]) begin
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && pend[(m_ptr[v] + k) % NR] && int'(pdata[(m_ptr[v] + k) % NR][63]) == v)
            w = (m_ptr[v] + k) % NR;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      ed = m_valid[u] ? m_data[u] : 64'd0;
      #2;
      check_out($sformatf("rnd%0d", c), eg, m_valid[u], ed, m_pol);
      if (w >= 0) begin
        m_valid[v] = 1'b1;
        m_data[v]  = pdata[w];
        m_ptr[v]   = (w + 1) % NR;
        pend[w]    = 1'b0;
      end
      if (m_valid[u] && ro) m_valid[u] = 1'b0;
      m_pol = ~m_pol;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
